// File: rtl/dfr_pkg.sv
// Shared types and constants for the delay-feedback reservoir input scheduler.
package dfr_pkg;

  localparam int unsigned DFR_VIRTUAL_NODES = 10;
  localparam int unsigned NODE_WIDTH        = $clog2(DFR_VIRTUAL_NODES);
  localparam int unsigned SAMPLE_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    INJECT,
    DRAIN
  } state_t;

  // Travels alongside each injected reservoir input until the matching output returns.
  typedef struct packed {
    logic                    valid;
    logic [NODE_WIDTH-1:0]   node;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    last;
  } tag_t;

endpackage

// File: rtl/dfr_tag_pipe.sv
// Fixed-depth delay line for node tags; matches the reservoir's input-to-output latency.
module dfr_tag_pipe
  import dfr_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_entry,
  output tag_t tag_exit,
  output logic empty
);

  tag_t stage [DEPTH];

  // Shift tags one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_entry;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_exit = stage[DEPTH-1];

  // Pipe is empty when no stage carries a valid tag.
  always_comb begin
    empty = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (stage[i].valid) begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dfr_input_scheduler.sv
// Feeds masked input samples to the reservoir, one cycle per virtual node,
// and tags the returning reservoir outputs for the readout layer.
module dfr_input_scheduler
  import dfr_pkg::*;
#(
  parameter int unsigned                     VIRTUAL_NODES = 10,
  parameter int unsigned                     DATA_WIDTH    = 32,
  parameter logic [VIRTUAL_NODES-1:0]        MASK          = 10'b1011001010,
  parameter int unsigned                     RES_LATENCY   = 1,
  parameter int unsigned                     WARMUP        = 2,
  parameter int unsigned                     CNT_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [CNT_WIDTH-1:0]              num_samples,
  output logic                              busy,
  output logic                              done,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [DATA_WIDTH-1:0]             res_din,
  input  logic [DATA_WIDTH-1:0]             res_dout,
  output logic [DATA_WIDTH-1:0]             node_data,
  output logic [$clog2(VIRTUAL_NODES)-1:0]  node_idx,
  output logic [CNT_WIDTH-1:0]              node_sample,
  output logic                              node_valid,
  output logic                              node_last
);

  localparam int unsigned    NW        = $clog2(VIRTUAL_NODES);
  localparam logic [NW-1:0]  LAST_NODE = NW'(VIRTUAL_NODES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [NW-1:0]          node_cnt;
  logic [NW-1:0]          node_next;
  logic [DATA_WIDTH-1:0]  sample;
  logic [DATA_WIDTH-1:0]  sample_next;
  logic [DATA_WIDTH-1:0]  din_next;
  logic [CNT_WIDTH-1:0]   num_lat;
  logic [CNT_WIDTH-1:0]   accepted;
  logic [CNT_WIDTH-1:0]   cur_sample;
  logic                   last_node;
  logic                   more;
  logic                   accept;
  logic                   done_next;
  tag_t                   tag_entry;
  tag_t                   tag_exit;
  logic                   pipe_empty;
  logic                   keep;

  assign last_node = (node_cnt == LAST_NODE);
  // accepted already counts the sample being injected
  assign more      = (accepted < num_lat);
  assign s_ready   = (state == FETCH) || ((state == INJECT) && last_node && more);
  assign accept    = s_ready && s_valid;

  // Next-state, next node/sample and the masked word that res_din will hold next cycle.
  always_comb begin
    state_next  = state;
    node_next   = node_cnt;
    sample_next = sample;
    done_next   = 1'b0;
    din_next    = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_samples != '0) state_next = FETCH;
          else                   done_next  = 1'b1;
        end
      end
      FETCH: begin
        if (accept) begin
          state_next  = INJECT;
          node_next   = '0;
          sample_next = s_data;
        end
      end
      INJECT: begin
        if (!last_node) begin
          node_next = node_cnt + NW'(1);
        end else if (accept) begin
          node_next   = '0;
          sample_next = s_data;
        end else if (more) begin
          state_next = FETCH;
        end else begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // empty pipe means the final tag is in the output register this cycle
        if (pipe_empty) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == INJECT) begin
      din_next = MASK[node_next] ? sample_next : -sample_next;
    end
  end

  // Control registers and the registered reservoir input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      node_cnt   <= '0;
      sample     <= '0;
      num_lat    <= '0;
      accepted   <= '0;
      cur_sample <= '0;
      res_din    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state    <= state_next;
      node_cnt <= node_next;
      sample   <= sample_next;
      res_din  <= din_next;
      done     <= done_next;
      busy     <= (state_next != IDLE);
      if ((state == IDLE) && start) begin
        num_lat  <= num_samples;
        accepted <= '0;
      end
      if (accept) begin
        cur_sample <= accepted;
        accepted   <= accepted + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    tag_entry        = '0;
    tag_entry.valid  = (state == INJECT);
    tag_entry.node   = node_cnt;
    tag_entry.sample = cur_sample;
    tag_entry.last   = last_node && !more;
  end

  dfr_tag_pipe #(
    .DEPTH(RES_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_entry (tag_entry),
    .tag_exit  (tag_exit),
    .empty     (pipe_empty)
  );

  assign keep = tag_exit.valid && (tag_exit.sample >= CNT_WIDTH'(WARMUP));

  // Capture the reservoir output paired with the exiting tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      node_data   <= '0;
      node_idx    <= '0;
      node_sample <= '0;
      node_valid  <= 1'b0;
      node_last   <= 1'b0;
    end else begin
      node_valid <= keep;
      node_last  <= keep && tag_exit.last;
      if (tag_exit.valid) begin
        node_data   <= res_dout;
        node_idx    <= tag_exit.node;
        node_sample <= tag_exit.sample;
      end
    end
  end

endmodule

// File: tb/tb_dfr_input_scheduler.sv
// Directed bench for dfr_input_scheduler: one instance with WARMUP=0 (a_*) and one
// with the default WARMUP=2 (b_*) share stimulus; each has an inverting 1-cycle reservoir.
module tb_dfr_input_scheduler;

  localparam logic [31:0] SAMP    = 32'h028F_5C29;
  localparam logic [9:0]  MASK_TB = 10'b1011001010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;

  logic        a_busy, a_done, a_s_ready, a_node_valid, a_node_last;
  logic [31:0] a_res_din, a_node_data;
  logic [31:0] a_res_dout = '0;
  logic [3:0]  a_node_idx;
  logic [15:0] a_node_sample;
  logic        b_busy, b_done, b_s_ready, b_node_valid, b_node_last;
  logic [31:0] b_res_din, b_node_data;
  logic [31:0] b_res_dout = '0;
  logic [3:0]  b_node_idx;
  logic [15:0] b_node_sample;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic [15:0] smp;
    logic        last;
    int          cyc;
  } obs_t;

  obs_t        qa[$];
  obs_t        qb[$];
  obs_t        oa, ob;
  int          done_a[$];
  int          done_b[$];
  logic [31:0] resd[$];
  int          resc[$];

  always #5 clk = ~clk;

  dfr_input_scheduler #(.WARMUP(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .busy(a_busy), .done(a_done), .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
    .res_din(a_res_din), .res_dout(a_res_dout), .node_data(a_node_data), .node_idx(a_node_idx),
    .node_sample(a_node_sample), .node_valid(a_node_valid), .node_last(a_node_last)
  );

  dfr_input_scheduler #(.WARMUP(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .busy(b_busy), .done(b_done), .s_data(s_data), .s_valid(s_valid), .s_ready(b_s_ready),
    .res_din(b_res_din), .res_dout(b_res_dout), .node_data(b_node_data), .node_idx(b_node_idx),
    .node_sample(b_node_sample), .node_valid(b_node_valid), .node_last(b_node_last)
  );

  // Reservoir stand-ins: one cycle of latency, inverted so the captured word differs from res_din.
  always @(posedge clk) begin
    a_res_dout <= ~a_res_din;
    b_res_dout <= ~b_res_din;
    cyc        <= cyc + 1;
  end

  // Log outputs away from the active edge.
  always @(negedge clk) begin
    if (a_node_valid) begin
      oa.data = a_node_data; oa.idx = a_node_idx; oa.smp = a_node_sample;
      oa.last = a_node_last; oa.cyc = cyc;
      qa.push_back(oa);
    end
    if (b_node_valid) begin
      ob.data = b_node_data; ob.idx = b_node_idx; ob.smp = b_node_sample;
      ob.last = b_node_last; ob.cyc = cyc;
      qb.push_back(ob);
    end
    if (a_done) done_a.push_back(cyc);
    if (b_done) done_b.push_back(cyc);
    if (a_busy) begin
      resd.push_back(a_res_din);
      resc.push_back(cyc);
    end
  end

  function automatic logic [31:0] masked(input logic [31:0] v, input int j);
    logic [9:0] m;
    m = MASK_TB;
    return m[j] ? v : -v;
  endfunction

  task automatic clear_logs();
    qa.delete(); qb.delete(); done_a.delete(); done_b.delete();
    resd.delete(); resc.delete();
  endtask

  // Stream n samples (SAMP*1, SAMP*2, ...); gap = refused ready cycles between samples;
  // poke = iteration at which start is re-pulsed with num_samples=7 (-1 for none).
  task automatic run_stream(input int n, input int gap, input int poke);
    int k, skip, g;
    bit seen;
    start = 1'b1;
    num_samples = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; skip = 0; g = 0;
    while (k < n && g < 2000) begin
      start   = (g == poke);
      if (g == poke) num_samples = 16'd7;
      s_valid = (skip == 0);
      s_data  = SAMP * 32'(k + 1);
      @(negedge clk);
      if (a_s_ready) begin
        if (s_valid) begin k++; skip = gap; end
        else skip--;
      end
      @(posedge clk); #1;
      g++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (k != n) begin
      failures++;
      $display("FAIL stream_accept got=%0d samples required=%0d", k, n);
    end
    seen = 0; g = 0;
    while (!seen && g < 200) begin
      @(negedge clk);
      if (a_done) seen = 1;
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL run_done got=timeout required=done pulse");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (a_busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
    checks++; if (a_s_ready !== 1'b0)     begin failures++; $display("FAIL reset_s_ready got=%b exp=0", a_s_ready); end
    checks++; if (a_res_din !== 32'h0)    begin failures++; $display("FAIL reset_res_din got=%h exp=0", a_res_din); end
    checks++; if (a_node_valid !== 1'b0)  begin failures++; $display("FAIL reset_node_valid got=%b exp=0", a_node_valid); end
    checks++; if (a_node_data !== 32'h0)  begin failures++; $display("FAIL reset_node_data got=%h exp=0", a_node_data); end
    checks++; if (a_node_idx !== 4'h0)    begin failures++; $display("FAIL reset_node_idx got=%0d exp=0", a_node_idx); end
    checks++; if (a_node_sample !== 16'h0) begin failures++; $display("FAIL reset_node_sample got=%0d exp=0", a_node_sample); end
    checks++; if (a_node_last !== 1'b0)   begin failures++; $display("FAIL reset_node_last got=%b exp=0", a_node_last); end
    checks++; if (b_busy !== 1'b0)        begin failures++; $display("FAIL reset_b_busy got=%b exp=0", b_busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [31:0] nz[$];
    int f;
    clear_logs();
    run_stream(1, 0, -1);
    repeat (6) @(posedge clk);
    #1;
    f = -1;
    foreach (resd[i]) if (resd[i] !== 32'h0) begin nz.push_back(resd[i]); if (f < 0) f = resc[i]; end
    checks++; if (nz.size() != 10) begin failures++; $display("FAIL single_inject_count got=%0d exp=10", nz.size()); end
    if (nz.size() >= 2) begin
      checks++; if (nz[0] !== 32'hFD70_A3D7) begin failures++; $display("FAIL single_res_din0 got=%h exp=fd70a3d7", nz[0]); end
      checks++; if (nz[1] !== 32'h028F_5C29) begin failures++; $display("FAIL single_res_din1 got=%h exp=028f5c29", nz[1]); end
    end
    for (int j = 2; j < nz.size() && j < 10; j++) begin
      checks++;
      if (nz[j] !== masked(SAMP, j)) begin failures++; $display("FAIL single_res_din[%0d] got=%h exp=%h", j, nz[j], masked(SAMP, j)); end
    end
    checks++; if (qa.size() != 10) begin failures++; $display("FAIL single_node_count got=%0d exp=10", qa.size()); end
    for (int j = 0; j < qa.size() && j < 10; j++) begin
      checks++; if (qa[j].idx !== 4'(j)) begin failures++; $display("FAIL single_idx[%0d] got=%0d exp=%0d", j, qa[j].idx, j); end
      checks++; if (qa[j].smp !== 16'h0) begin failures++; $display("FAIL single_sample[%0d] got=%0d exp=0", j, qa[j].smp); end
      checks++; if (qa[j].data !== ~masked(SAMP, j)) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", j, qa[j].data, ~masked(SAMP, j)); end
      checks++; if (qa[j].last !== (j == 9)) begin failures++; $display("FAIL single_last[%0d] got=%b exp=%b", j, qa[j].last, (j == 9)); end
      checks++; if (qa[j].cyc != qa[0].cyc + j) begin failures++; $display("FAIL single_contig[%0d] got=%0d exp=%0d", j, qa[j].cyc, qa[0].cyc + j); end
    end
    if (qa.size() > 0) begin
      checks++; if (qa[0].cyc != f + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", qa[0].cyc, f + 2); end
    end
    checks++; if (done_a.size() != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_a.size()); end
    if (done_a.size() == 1 && qa.size() == 10) begin
      checks++; if (done_a[0] != qa[9].cyc + 1) begin failures++; $display("FAIL single_done_timing got=%0d exp=%0d", done_a[0], qa[9].cyc + 1); end
    end
    checks++; if (qb.size() != 0) begin failures++; $display("FAIL single_warmup_b got=%0d exp=0", qb.size()); end
    checks++; if (done_b.size() != 1) begin failures++; $display("FAIL single_done_b got=%0d exp=1", done_b.size()); end
  endtask

  task automatic test_back_to_back();
    int f, nzc;
    logic [31:0] v;
    clear_logs();
    run_stream(4, 0, -1);
    repeat (6) @(posedge clk);
    #1;
    f = -1; nzc = 0;
    foreach (resd[i]) if (resd[i] !== 32'h0) begin nzc++; if (f < 0) f = i; end
    checks++; if (nzc != 40) begin failures++; $display("FAIL b2b_inject_count got=%0d exp=40", nzc); end
    for (int i = 0; i < 40 && f >= 0 && f + i < resd.size(); i++) begin
      v = SAMP * 32'(i / 10 + 1);
      checks++;
      if (resd[f+i] !== masked(v, i % 10)) begin failures++; $display("FAIL b2b_res_din[%0d] got=%h exp=%h", i, resd[f+i], masked(v, i % 10)); end
    end
    checks++; if (qa.size() != 40) begin failures++; $display("FAIL b2b_a_count got=%0d exp=40", qa.size()); end
    checks++; if (qb.size() != 20) begin failures++; $display("FAIL b2b_b_count got=%0d exp=20", qb.size()); end
    for (int i = 0; i < qb.size() && i < 20; i++) begin
      v = SAMP * 32'(i / 10 + 3);
      checks++; if (qb[i].smp !== 16'(2 + i / 10)) begin failures++; $display("FAIL b2b_sample[%0d] got=%0d exp=%0d", i, qb[i].smp, 2 + i / 10); end
      checks++; if (qb[i].idx !== 4'(i % 10)) begin failures++; $display("FAIL b2b_idx[%0d] got=%0d exp=%0d", i, qb[i].idx, i % 10); end
      checks++; if (qb[i].data !== ~masked(v, i % 10)) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, qb[i].data, ~masked(v, i % 10)); end
      checks++; if (qb[i].last !== (i == 19)) begin failures++; $display("FAIL b2b_last[%0d] got=%b exp=%b", i, qb[i].last, (i == 19)); end
      checks++; if (qb[i].cyc != qb[0].cyc + i) begin failures++; $display("FAIL b2b_contig[%0d] got=%0d exp=%0d", i, qb[i].cyc, qb[0].cyc + i); end
    end
    if (qb.size() == 20 && done_b.size() == 1) begin
      checks++; if (done_b[0] != qb[19].cyc + 1) begin failures++; $display("FAIL b2b_done_timing got=%0d exp=%0d", done_b[0], qb[19].cyc + 1); end
    end else begin
      checks++; failures++;
      $display("FAIL b2b_done_count got=%0d exp=1", done_b.size());
    end
  endtask

  task automatic test_gapped();
    int f;
    logic [31:0] v, e;
    clear_logs();
    run_stream(3, 3, -1);
    repeat (6) @(posedge clk);
    #1;
    f = -1;
    foreach (resd[i]) if (resd[i] !== 32'h0 && f < 0) f = i;
    checks++; if (f < 0 || f + 36 > resd.size()) begin failures++; $display("FAIL gap_trace_len got=%0d exp>=36", resd.size()); end
    for (int i = 0; i < 36 && f >= 0 && f + i < resd.size(); i++) begin
      v = SAMP * 32'(i / 13 + 1);
      e = ((i % 13) >= 10) ? 32'h0 : masked(v, i % 13);
      checks++;
      if (resd[f+i] !== e) begin failures++; $display("FAIL gap_res_din[%0d] got=%h exp=%h", i, resd[f+i], e); end
    end
    checks++; if (qa.size() != 30) begin failures++; $display("FAIL gap_a_count got=%0d exp=30", qa.size()); end
    for (int i = 0; i < qa.size() && i < 30; i++) begin
      checks++; if (qa[i].idx !== 4'(i % 10)) begin failures++; $display("FAIL gap_idx[%0d] got=%0d exp=%0d", i, qa[i].idx, i % 10); end
      checks++; if (qa[i].smp !== 16'(i / 10)) begin failures++; $display("FAIL gap_sample[%0d] got=%0d exp=%0d", i, qa[i].smp, i / 10); end
      if (i % 10 != 0) begin
        checks++; if (qa[i].cyc != qa[i-1].cyc + 1) begin failures++; $display("FAIL gap_contig[%0d] got=%0d exp=%0d", i, qa[i].cyc, qa[i-1].cyc + 1); end
      end
    end
    checks++; if (qb.size() != 10) begin failures++; $display("FAIL gap_b_count got=%0d exp=10", qb.size()); end
    if (qb.size() > 0) begin
      checks++; if (qb[0].smp !== 16'd2) begin failures++; $display("FAIL gap_b_sample got=%0d exp=2", qb[0].smp); end
    end
  endtask

  task automatic test_zero_and_busy_start();
    clear_logs();
    start = 1'b1;
    num_samples = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b1)    begin failures++; $display("FAIL zero_done got=%b exp=1", a_done); end
    checks++; if (a_busy !== 1'b0)    begin failures++; $display("FAIL zero_busy got=%b exp=0", a_busy); end
    checks++; if (a_s_ready !== 1'b0) begin failures++; $display("FAIL zero_s_ready got=%b exp=0", a_s_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (a_done !== 1'b0)    begin failures++; $display("FAIL zero_done_width got=%b exp=0", a_done); end
    checks++; if (a_s_ready !== 1'b0) begin failures++; $display("FAIL zero_s_ready2 got=%b exp=0", a_s_ready); end
    @(posedge clk); #1;
    checks++; if (done_a.size() != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_a.size()); end

    clear_logs();
    run_stream(2, 0, 5);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (qa.size() != 20) begin failures++; $display("FAIL busy_start_count got=%0d exp=20", qa.size()); end
    if (qa.size() == 20) begin
      checks++; if (qa[19].last !== 1'b1) begin failures++; $display("FAIL busy_start_last got=%b exp=1", qa[19].last); end
      checks++; if (qa[19].smp !== 16'd1) begin failures++; $display("FAIL busy_start_sample got=%0d exp=1", qa[19].smp); end
    end
    checks++; if (done_a.size() != 1) begin failures++; $display("FAIL busy_start_done got=%0d exp=1", done_a.size()); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", a_busy); end
  endtask

  task automatic test_reset_mid();
    int cnt, g;
    clear_logs();
    start = 1'b1;
    num_samples = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = SAMP * 32'd2;
    cnt = 0; g = 0;
    while (cnt < 15 && g < 100) begin
      @(negedge clk);
      if (a_res_din !== 32'h0) cnt++;
      @(posedge clk); #1;
      g++;
    end
    checks++; if (cnt != 15) begin failures++; $display("FAIL midrst_reach got=%0d exp=15", cnt); end
    // this cycle is node 5 of sample 1
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    checks++; if (a_busy !== 1'b0)       begin failures++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
    checks++; if (a_s_ready !== 1'b0)    begin failures++; $display("FAIL midrst_s_ready got=%b exp=0", a_s_ready); end
    checks++; if (a_res_din !== 32'h0)   begin failures++; $display("FAIL midrst_res_din got=%h exp=0", a_res_din); end
    checks++; if (a_node_valid !== 1'b0) begin failures++; $display("FAIL midrst_node_valid got=%b exp=0", a_node_valid); end
    checks++; if (a_node_data !== 32'h0) begin failures++; $display("FAIL midrst_node_data got=%h exp=0", a_node_data); end
    checks++; if (a_done !== 1'b0)       begin failures++; $display("FAIL midrst_done got=%b exp=0", a_done); end
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (qa.size() != 0)     begin failures++; $display("FAIL midrst_flushed got=%0d outputs exp=0", qa.size()); end
    checks++; if (done_a.size() != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_a.size()); end
    checks++; if (a_busy !== 1'b0)    begin failures++; $display("FAIL midrst_idle got=%b exp=0", a_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_zero_and_busy_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfr_input_scheduler.md
Name: dfr_input_scheduler

Overview:
- Sequences input samples into the delay-feedback reservoir core.
- Each accepted sample is held for VIRTUAL_NODES consecutive cycles, one cycle per virtual node, and multiplied by a per-node ±1 input mask.
- Tags each reservoir output with its sample and node index, suppresses warm-up outputs, and streams node states to the readout layer.
- Sits between the sample source (valid/ready) and the reservoir din/dout pair.

Parameters:
- VIRTUAL_NODES, 10, virtual nodes per sample (≥2).
- DATA_WIDTH, 32, sample/reservoir word width, two's complement.
- MASK, 10'b1011001010, per-node input mask; bit j=1 → +x, bit j=0 → −x.
- RES_LATENCY, 1, cycles from res_din valid to the matching res_dout valid (≥1).
- WARMUP, 2, leading samples whose node outputs are discarded.
- CNT_WIDTH, 16, width of sample counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  one-cycle run request.
- num_samples  in  CNT_WIDTH  samples in the run; latched on start.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- s_data  in  DATA_WIDTH  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accept.
- res_din  out  DATA_WIDTH  masked sample to reservoir (registered).
- res_dout  in  DATA_WIDTH  reservoir output.
- node_data  out  DATA_WIDTH  captured node state.
- node_idx  out  clog2(VIRTUAL_NODES)  virtual node index.
- node_sample  out  CNT_WIDTH  sample index, counted from 0, warm-up samples included.
- node_valid  out  1  node output valid; no backpressure.
- node_last  out  1  with node_valid: last node of last sample.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset:
  - state=IDLE.
  - All outputs 0: busy, done, s_ready, res_din, node_*.
  - Counters cleared; tag pipeline flushed.
  - Reset mid-run aborts the run with no done pulse.
- States: IDLE, FETCH, INJECT, DRAIN.
- IDLE:
  - res_din=0, s_ready=0.
  - start with num_samples>0 → FETCH, busy=1.
  - start with num_samples=0 → done pulse the next cycle; stay IDLE.
  - start while busy is ignored.
- FETCH:
  - s_ready=1, res_din=0.
  - s_valid&s_ready latches the sample → INJECT with node_cnt=0.
  - While waiting, res_din stays 0. These zero cycles are real reservoir inputs and are not tagged.
- INJECT:
  - res_din = MASK[node_cnt] ? x : −x (two's-complement negate, wraps; −min = min).
  - Registered: res_din for node j is valid in cycle t_j.
  - node_cnt increments each cycle.
- Last node (node_cnt=VIRTUAL_NODES−1):
  - If samples remain, s_ready=1 in this cycle.
  - If s_valid is also high, the next sample is accepted and INJECT restarts at node 0 with no bubble.
  - If samples remain but s_valid is low → FETCH.
  - If this was the last sample → DRAIN.
- Tag pipeline:
  - Each INJECT cycle pushes {valid, node, sample, last} into a RES_LATENCY-deep delay line.
  - At t_j+RES_LATENCY the tag exits and res_dout is registered into node_data.
  - node_valid goes high at t_j+RES_LATENCY+1 if tag.sample ≥ WARMUP.
- DRAIN:
  - res_din=0.
  - Waits until the tag pipeline is empty and the last output register cycle has passed.
  - Then done=1 for one cycle, busy=0, → IDLE.
  - done follows node_last by exactly one cycle. It also fires when every sample was warm-up, in which case no node_valid ever occurs.
- s_ready is never high in IDLE or DRAIN.
- s_data is sampled only on handshake.

Decomposition:
- Shared package dfr_pkg:
  - state enum (IDLE/FETCH/INJECT/DRAIN).
  - node-index width constant clog2(VIRTUAL_NODES).
  - tag struct {valid, node, sample, last}.
- Sub-module dfr_tag_pipe:
  - Parameterised-depth shift register of tags.
  - Synchronous clear on rst.

Test Plan:
- Reset: rst high 5 cycles, then observe 1 cycle → all outputs 0, state IDLE, s_ready=0.
- Single sample, WARMUP=0, num_samples=1, s_data=32'h028F_5C29, default MASK (node j uses bit j of MASK):
  - res_din over nodes 0..9 = 0xFD70A3D7 where the mask bit is 0, 0x028F5C29 where it is 1.
  - node_valid for 10 consecutive cycles, node_idx 0..9.
  - node_last on idx 9; done exactly one cycle later.
- Back-to-back run, num_samples=4, s_valid held high, samples 0x028F5C29·k:
  - 40 contiguous INJECT cycles, no zero gap.
  - node_valid only for samples 2–3 (20 outputs); node_sample 2,3.
- Gapped source, s_valid low 3 cycles between samples → res_din=0 for exactly 3 cycles; node indices continue correctly, no spurious node_valid.
- num_samples=0, and start pulsed while busy:
  - num_samples=0 → done pulse the next cycle, s_ready never high.
  - start while busy → no effect on counters.
- rst asserted at node 5 of sample 1 → next cycle IDLE, outputs 0, no done, no node_valid from flushed tags.
